// File: rtl/burst_pattern_sched.sv
// Clock-enable burst scheduler: a programmable divider paces a burst of tog
// toggles followed by a hold window, optionally repeating until stopped.
module burst_pattern_sched #(
    parameter int DIV_W = 21,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_pulses,
    input  logic [CNT_W-1:0] cfg_hold,
    input  logic             cfg_repeat,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             tick,
    output logic             tog,
    output logic             hold_o,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [CNT_W-1:0] pul_l_q, pul_l_d;
    logic [CNT_W-1:0] hold_l_q, hold_l_d;
    logic             rep_l_q, rep_l_d;
    logic             tog_q, tog_d;
    logic             hold_o_q, hold_o_d;
    logic             done_q, done_d;
    logic             end_of_burst;

    assign busy   = (state_q != S_IDLE);
    assign tick   = busy & (div_cnt_q == div_l_q);
    assign tog    = tog_q;
    assign hold_o = hold_o_q;
    assign done   = done_q;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        div_l_d      = div_l_q;
        ph_d         = ph_q;
        pul_l_d      = pul_l_q;
        hold_l_d     = hold_l_q;
        rep_l_d      = rep_l_q;
        tog_d        = tog_q;
        hold_o_d     = hold_o_q;
        done_d       = 1'b0;
        end_of_burst = 1'b0;

        if (busy) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end

        if (stop) begin
            // Abort wins over everything but reset; no completion pulse.
            state_d   = S_IDLE;
            div_cnt_d = '0;
            ph_d      = '0;
            tog_d     = 1'b1;
            hold_o_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                div_l_d   = cfg_div;
                pul_l_d   = cfg_pulses;
                hold_l_d  = cfg_hold;
                rep_l_d   = cfg_repeat;
                div_cnt_d = '0;
                ph_d      = '0;
                tog_d     = 1'b1;
                if (cfg_pulses != '0) begin
                    state_d = S_PULSE;
                end else if (cfg_hold != '0) begin
                    state_d  = S_HOLD;
                    hold_o_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (tick) begin
            case (state_q)
                S_PULSE: begin
                    tog_d = ~tog_q;
                    if (ph_q == pul_l_q - 1'b1) begin
                        ph_d = '0;
                        if (hold_l_q != '0) begin
                            state_d  = S_HOLD;
                            hold_o_d = 1'b1;
                        end else begin
                            end_of_burst = 1'b1;
                        end
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (ph_q == hold_l_q - 1'b1) begin
                        ph_d         = '0;
                        hold_o_d     = 1'b0;
                        end_of_burst = 1'b1;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // tog is deliberately left alone here so repeated bursts keep phase.
            if (end_of_burst) begin
                if (rep_l_q) begin
                    if (pul_l_q != '0) begin
                        state_d = S_PULSE;
                    end else begin
                        state_d  = S_HOLD;
                        hold_o_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            div_l_q   <= '0;
            ph_q      <= '0;
            pul_l_q   <= '0;
            hold_l_q  <= '0;
            rep_l_q   <= 1'b0;
            tog_q     <= 1'b1;
            hold_o_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_l_q   <= div_l_d;
            ph_q      <= ph_d;
            pul_l_q   <= pul_l_d;
            hold_l_q  <= hold_l_d;
            rep_l_q   <= rep_l_d;
            tog_q     <= tog_d;
            hold_o_q  <= hold_o_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_burst_pattern_sched.sv
// Bench for burst_pattern_sched: cycle-by-cycle comparison of the outputs
// against an arithmetic model of tick count, burst position and toggle parity.
module tb_burst_pattern_sched;

    localparam int DIV_W = 21;
    localparam int CNT_W = 8;
    localparam int NEVER = 1 << 30;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_pulses;
    logic [CNT_W-1:0] cfg_hold;
    logic             cfg_repeat;
    logic             start;
    logic             stop;
    logic             busy;
    logic             tick;
    logic             tog;
    logic             hold_o;
    logic             done;

    int total = 0;
    int bad   = 0;

    burst_pattern_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_div    (cfg_div),
        .cfg_pulses (cfg_pulses),
        .cfg_hold   (cfg_hold),
        .cfg_repeat (cfg_repeat),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .tick       (tick),
        .tog        (tog),
        .hold_o     (hold_o),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Outputs packed as {busy, tick, tog, hold_o, done}.
    localparam logic [4:0] IDLE_VEC = 5'b00100;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs n edges after the edge that sampled start.
    // c = completed ticks, b = position within the current burst.
    function automatic logic [4:0] model(input longint n, input longint dv, input longint pl,
                                         input longint hl, input bit rp);
        longint p, t, c, b, np;
        logic   tg;
        p = dv + 1;
        t = pl + hl;
        c = n / p;
        if (t == 0 || (!rp && c >= t)) begin
            tg = (t == 0) ? 1'b1 : ((pl % 2) == 0);
            return {1'b0, 1'b0, tg, 1'b0, (n == t * p)};
        end
        b  = rp ? (c % t) : c;
        np = (c / t) * pl + ((b < pl) ? b : pl);
        return {1'b1, ((n % p) == p - 1), ((np % 2) == 0), (b >= pl), 1'b0};
    endfunction

    task automatic run_burst(input string tag, input int dv, input int pl, input int hl,
                             input bit rp, input int ncyc, input int stop_at,
                             input int rst_at, input bit noise);
        longint     span;
        logic [4:0] exp;
        span       = longint'(pl + hl) * longint'(dv + 1);
        cfg_div    = DIV_W'(dv);
        cfg_pulses = CNT_W'(pl);
        cfg_hold   = CNT_W'(hl);
        cfg_repeat = rp;
        start      = 1'b1;
        step();
        start = 1'b0;
        check_val($sformatf("%s n=0", tag), {busy, tick, tog, hold_o, done}, model(0, dv, pl, hl, rp));
        for (int n = 1; n <= ncyc; n++) begin
            stop = (n == stop_at);
            rst  = (n == rst_at);
            if (noise && n < stop_at && n < rst_at && span > 0 && (rp || n < span)
                && $urandom_range(0, 3) == 0) begin
                start      = 1'b1;
                cfg_div    = DIV_W'($urandom_range(0, 7));
                cfg_pulses = CNT_W'($urandom);
                cfg_hold   = CNT_W'($urandom);
                cfg_repeat = 1'($urandom);
            end
            step();
            start = 1'b0;
            stop  = 1'b0;
            rst   = 1'b0;
            exp   = (n >= stop_at || n >= rst_at) ? IDLE_VEC : model(n, dv, pl, hl, rp);
            check_val($sformatf("%s n=%0d", tag, n), {busy, tick, tog, hold_o, done}, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        cfg_div    = '0;
        cfg_pulses = '0;
        cfg_hold   = '0;
        cfg_repeat = 1'b0;
        step();
        step();
        check_val("reset", {busy, tick, tog, hold_o, done}, IDLE_VEC);
        rst = 1'b0;
        step();
        check_val("post_reset", {busy, tick, tog, hold_o, done}, IDLE_VEC);

        run_burst("tp1", 3, 9, 20, 1'b0, 120, NEVER, NEVER, 1'b1);
        run_burst("tp2", 0, 4, 2, 1'b1, 20, 17, NEVER, 1'b1);

        cfg_div    = DIV_W'(2);
        cfg_pulses = CNT_W'(3);
        cfg_hold   = CNT_W'(3);
        start      = 1'b1;
        stop       = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_val("start_stop_idle", {busy, tick, tog, hold_o, done}, IDLE_VEC);
        step();
        check_val("start_stop_idle2", {busy, tick, tog, hold_o, done}, IDLE_VEC);

        run_burst("tp3a", 0, 0, 0, 1'b0, 4, NEVER, NEVER, 1'b0);
        run_burst("tp3b", 1, 0, 5, 1'b0, 14, NEVER, NEVER, 1'b0);
        run_burst("tp5_rst", 2, 9, 3, 1'b0, 20, NEVER, 15, 1'b0);
        run_burst("tp5_after", 2, 9, 3, 1'b0, 40, NEVER, NEVER, 1'b0);
        run_burst("tp6", 0, 255, 255, 1'b0, 513, NEVER, NEVER, 1'b0);

        for (int s = 0; s < 20; s++) begin
            int dv, pl, hl, span, ncyc, stop_at;
            bit rp;
            dv      = $urandom_range(0, 4);
            pl      = $urandom_range(0, 12);
            hl      = $urandom_range(0, 12);
            rp      = 1'($urandom);
            span    = (pl + hl) * (dv + 1);
            stop_at = NEVER;
            if (rp) begin
                stop_at = $urandom_range(1, 2 * span + 5);
                ncyc    = stop_at + 3;
            end else begin
                ncyc = span + 3;
                if ($urandom_range(0, 2) == 0) stop_at = $urandom_range(1, span + 1);
            end
            run_burst($sformatf("rnd%0d", s), dv, pl, hl, rp, ncyc, stop_at, NEVER, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_pattern_sched.md
Name: burst_pattern_sched

Overview:
- Single-clock scheduler that replaces the derived-clock divider and pattern logic with a clock-enable design.
- An internal programmable divider produces a one-cycle tick. A state machine sequences a burst of tick-paced toggles on tog, then a hold window on hold_o, then completes or repeats.
- Sits between the control/config logic and the pattern output pins. Started and stopped by handshake; no generated clocks.

Parameters:
- DIV_W, 21, width of the divider count and of cfg_div.
- CNT_W, 8, width of the phase counter, cfg_pulses and cfg_hold.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- cfg_div  in  DIV_W  tick period minus 1, in clk cycles.
- cfg_pulses  in  CNT_W  number of tog toggles per burst.
- cfg_hold  in  CNT_W  hold window length, in ticks.
- cfg_repeat  in  1  1 = loop PULSE/HOLD until stop; 0 = single burst.
- start  in  1  one-cycle request; honoured only in IDLE.
- stop  in  1  abort; honoured in any state.
- busy  out  1  high while not IDLE.
- tick  out  1  divider strobe, one cycle wide.
- tog  out  1  toggling pattern output.
- hold_o  out  1  high during the HOLD state.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset values: state=IDLE, div_cnt=0, ph=0, busy=0, tog=1, hold_o=0, done=0. Latched config regs are cleared to 0.
- tick = busy & (div_cnt == div_l), decoded from registers.
- div_cnt increments each cycle while busy and wraps to 0 on tick. cfg_div=0 gives tick every cycle.
- cfg_* are latched into div_l, pul_l, hold_l, rep_l on an accepted start. Later cfg changes have no effect until the next start.
- Priority, highest first: rst > stop > start > tick.
- IDLE:
  - On start with stop=0: latch config, div_cnt<=0, ph<=0, tog<=1.
  - Next state is PULSE if pul_l!=0, else HOLD if hold_l!=0.
  - If both are 0: stay IDLE and pulse done the next cycle.
- PULSE: on tick, tog<=~tog and ph<=ph+1.
  - On the tick where ph==pul_l-1: ph<=0.
  - Next state is HOLD if hold_l!=0. Otherwise it is the end-of-burst action.
- HOLD: hold_o=1 (registered; set on entry, cleared on exit). On tick, ph<=ph+1.
  - On the tick where ph==hold_l-1: ph<=0, hold_o<=0, then the end-of-burst action.
- End-of-burst action:
  - rep_l=1: enter PULSE, or HOLD if pul_l==0. tog is not reset.
  - rep_l=0: go to IDLE, busy<=0, done<=1 for exactly one cycle.
- stop while busy: next cycle IDLE, div_cnt=0, ph=0, tog=1, hold_o=0. No done pulse is generated.
- start while busy is ignored. start and stop in the same IDLE cycle: stop wins and nothing starts.
- Timing:
  - First tick occurs in the cycle div_l clk edges after the start-sampling edge.
  - Tick k (k>=1) occurs (div_l+1)*k - 1 edges after that edge.
  - The tog/ph update occurs on the edge that ends the tick cycle.
- Burst length: (pul_l+hold_l)*(div_l+1) cycles. done is visible the cycle after the last tick.
- ph never exceeds max(pul_l,hold_l)-1. No wrap-around for CNT_W-bit values, including 255.
- rst asserted mid-burst behaves as reset. No done pulse; outputs take their reset values on the next edge.

Test Plan:
1. cfg_div=3, cfg_pulses=9, cfg_hold=20, repeat=0, start at edge E0 -> tick every 4 cycles; tog toggles 9 times, last at E0+36 (ends at 0). hold_o high from E0+36 to E0+116. done high exactly one cycle after E0+116; busy falls at E0+116.
2. cfg_div=0, pulses=4, hold=2, repeat=1 -> tog toggles every cycle for 4 cycles, then hold_o high 2 cycles, looping. stop mid-HOLD -> next cycle busy=0, hold_o=0, tog=1, done never asserted.
3. pulses=0, hold=0, start -> busy stays 0; done pulses one cycle later. pulses=0, hold=5, div=1 -> hold_o high for 10 cycles, then done.
4. start and stop asserted together in IDLE -> no state change. start during an active burst, with cfg changed -> ignored; burst timing unchanged.
5. rst asserted at tick 5 of the PULSE phase -> next edge: busy=0, tog=1, hold_o=0, tick=0, done=0. A subsequent start runs a full, correct burst.
6. pulses=255, hold=255, div=0 -> exactly 255 toggles and 255 hold cycles. done 510 cycles after start; no counter wrap.
